// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment scanner.
// Glyphs are active-low with bit 0 = segment a through bit 6 = segment g.
package display_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [3:0] AN_ONEHOT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz_sup;
  } disp_word_t;

endpackage

// File: rtl/display_scan_ctrl_decode.sv
// BCD digit to active-low seven-segment glyph; non-decimal codes render as a dash.
module digit_seg_decode
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) seg = SEG_DIGIT[i];
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scanner for four BCD digits with a double-buffered display
// register that only updates at frame end, so a frame never mixes two values.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_sup,
  output logic        ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  disp_word_t    shadow_reg;
  disp_word_t    disp_reg;
  logic          pending_reg;

  logic          tick;
  logic          frame_end;
  logic          slot_active;
  logic [3:0]    upper_zero;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [6:0]    dec_seg;

  assign tick      = (presc_reg == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx_reg == 2'd3);

  if (BLANK_CYC == 0) begin : g_no_blank
    assign slot_active = 1'b1;
  end else begin : g_blank
    assign slot_active = (presc_reg >= PW'(BLANK_CYC));
  end

  // upper_zero[i]: digit i and every more-significant digit are zero
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_upper_zero
    assign upper_zero[gi] = (disp_reg.value[15:4*gi] == '0);
  end

  assign cur_digit = disp_reg.value[{idx_reg, 2'b00} +: 4];
  assign cur_blank = disp_reg.lz_sup && (idx_reg != 2'd0) && upper_zero[idx_reg];

  digit_seg_decode u_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg   <= '0;
      idx_reg     <= 2'd0;
      shadow_reg  <= '0;
      disp_reg    <= '0;
      pending_reg <= 1'b0;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      an          <= 4'b1111;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick) idx_reg <= idx_reg + 2'd1;

      if (frame_end && pending_reg) begin
        disp_reg    <= shadow_reg;
        pending_reg <= 1'b0;
      end
      // A load on the commit cycle lands after the commit and stays pending.
      if (load) begin
        shadow_reg  <= {value, dp_in, lz_sup};
        pending_reg <= 1'b1;
      end

      seg <= cur_blank ? SEG_BLANK : dec_seg;
      dp  <= cur_blank | ~disp_reg.dp[idx_reg];
      an  <= (en && slot_active) ? AN_ONEHOT[idx_reg] : 4'b1111;
    end
  end

  assign ready = ~pending_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a cycle-level reference model
// checked every cycle plus literal glyph/anode expectations.
module tb_display_scan_ctrl;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_sup = 1'b0;
  logic        ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .lz_sup(lz_sup), .ready(ready), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'b1000000;  1: glyph = 7'b1111001;  2: glyph = 7'b0100100;
      3: glyph = 7'b0110000;  4: glyph = 7'b0011001;  5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;  7: glyph = 7'b1111000;  8: glyph = 7'b0000000;
      9: glyph = 7'b0010000;  default: glyph = 7'b0111111;
    endcase
  endfunction

  // Reference model: t counts cycles since reset; slot and phase follow from it.
  int          t;
  bit          mvalid = 1'b0;
  logic [15:0] sh_v, ds_v;
  logic [3:0]  sh_dp, ds_dp;
  logic        sh_lz, ds_lz, pend;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_ready;
  logic [3:0]  exp_an, onehot;
  int          m_idx, m_ph, m_d;
  bit          m_blank;

  always @(posedge clk) begin
    if (rst) begin
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
      t = 0; sh_v = 0; ds_v = 0; sh_dp = 0; ds_dp = 0; sh_lz = 0; ds_lz = 0; pend = 0;
      mvalid = 1'b1;
    end else begin
      m_ph    = t % SD;
      m_idx   = (t / SD) % 4;
      m_d     = int'((ds_v >> (4 * m_idx)) & 16'hF);
      m_blank = ds_lz && (m_idx > 0) && ((ds_v >> (4 * m_idx)) == 16'h0);
      exp_seg = m_blank ? 7'h7F : glyph(m_d);
      exp_dp  = m_blank ? 1'b1 : ~ds_dp[m_idx];
      onehot  = 4'b0001 << m_idx;
      exp_an  = (en && m_ph >= BC) ? ~onehot : 4'hF;
      if (m_ph == SD - 1 && m_idx == 3 && pend) begin
        ds_v = sh_v; ds_dp = sh_dp; ds_lz = sh_lz; pend = 0;
      end
      if (load) begin
        sh_v = value; sh_dp = dp_in; sh_lz = lz_sup; pend = 1;
      end
      t++;
    end
    exp_ready = ~pend;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_seg", {9'h0, seg}, {9'h0, exp_seg});
      chk("model_dp", {15'h0, dp}, {15'h0, exp_dp});
      chk("model_an", {12'h0, an}, {12'h0, exp_an});
      chk("model_ready", {15'h0, ready}, {15'h0, exp_ready});
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    value = v; dp_in = d; lz_sup = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (ready === 1'b1) seen = 1;
    end
    chk(name, {15'h0, seen}, 16'h1);
  endtask

  task automatic wait_phase(input int target);
    bit seen = 0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (t % FRAME == target) seen = 1;
    end
    chk("wait_phase", {15'h0, seen}, 16'h1);
  endtask

  task automatic check_digit(input string name, input logic [3:0] an_val,
                             input logic [6:0] seg_exp, input logic dp_exp);
    bit seen = 0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (an === an_val) seen = 1;
    end
    chk({name, "_found"}, {15'h0, seen}, 16'h1);
    if (seen) begin
      chk({name, "_seg"}, {9'h0, seg}, {9'h0, seg_exp});
      chk({name, "_dp"}, {15'h0, dp}, {15'h0, dp_exp});
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready", {15'h0, ready}, 16'h1);
    chk("rst_an", {12'h0, an}, 16'hF);
    chk("rst_seg", {9'h0, seg}, 16'h7F);
    chk("rst_dp", {15'h0, dp}, 16'h1);
    rst = 1'b0; en = 1'b1;

    // 1234, no suppression
    do_load(16'h1234, 4'h0, 1'b0);
    chk("ready_pending", {15'h0, ready}, 16'h0);
    wait_ready("ready_1234");
    check_digit("d0_1234", 4'b1110, 7'b0011001, 1'b1);
    check_digit("d1_1234", 4'b1101, 7'b0110000, 1'b1);
    check_digit("d2_1234", 4'b1011, 7'b0100100, 1'b1);
    check_digit("d3_1234", 4'b0111, 7'b1111001, 1'b1);
    n = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (an === 4'b1110) n++;
    end
    chk("d0_active_cycles", 16'(n), 16'd3);

    // leading-zero suppression on and off
    do_load(16'h0007, 4'h0, 1'b1);
    wait_ready("ready_0007_lz");
    check_digit("d3_lz", 4'b0111, 7'b1111111, 1'b1);
    check_digit("d2_lz", 4'b1011, 7'b1111111, 1'b1);
    check_digit("d1_lz", 4'b1101, 7'b1111111, 1'b1);
    check_digit("d0_lz", 4'b1110, 7'b1111000, 1'b1);
    do_load(16'h0007, 4'h0, 1'b0);
    wait_ready("ready_0007");
    check_digit("d3_nolz", 4'b0111, 7'b1000000, 1'b1);
    check_digit("d1_nolz", 4'b1101, 7'b1000000, 1'b1);

    // dash digit with decimal point, zero digit 0 survives suppression
    do_load(16'h00A0, 4'b0010, 1'b1);
    wait_ready("ready_00a0");
    check_digit("d1_dash", 4'b1101, 7'b0111111, 1'b0);
    check_digit("d0_zero", 4'b1110, 7'b1000000, 1'b1);
    check_digit("d2_blank", 4'b1011, 7'b1111111, 1'b1);
    check_digit("d3_blank", 4'b0111, 7'b1111111, 1'b1);

    // three loads in a frame, last one on the frame-end tick
    wait_phase(5);
    do_load(16'h1111, 4'h0, 1'b0);
    wait_phase(10);
    do_load(16'h2222, 4'h0, 1'b0);
    wait_phase(15);
    do_load(16'h3333, 4'h0, 1'b0);
    chk("ready_overlap", {15'h0, ready}, 16'h0);
    check_digit("d0_2222", 4'b1110, 7'b0100100, 1'b1);
    chk("ready_still_pending", {15'h0, ready}, 16'h0);
    wait_ready("ready_3333");
    check_digit("d0_3333", 4'b1110, 7'b0110000, 1'b1);

    // display disabled mid-frame
    wait_phase(6);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("en_off_an", {12'h0, an}, 16'hF);
    end
    en = 1'b1;
    check_digit("d2_after_en", 4'b1011, 7'b0110000, 1'b1);

    // reset with a pending load
    wait_phase(2);
    do_load(16'h5555, 4'hF, 1'b0);
    chk("ready_before_rst", {15'h0, ready}, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_ready", {15'h0, ready}, 16'h1);
    chk("rst2_an", {12'h0, an}, 16'hF);
    @(negedge clk);
    chk("rst2_seg", {9'h0, seg}, 16'h7F);
    rst = 1'b0;
    repeat (FRAME + 2) @(negedge clk);
    chk("ready_after_rst", {15'h0, ready}, 16'h1);
    check_digit("d0_post_rst", 4'b1110, 7'b1000000, 1'b1);
    check_digit("d1_post_rst", 4'b1101, 7'b1000000, 1'b1);
    check_digit("d2_post_rst", 4'b1011, 7'b1000000, 1'b1);
    check_digit("d3_post_rst", 4'b0111, 7'b1000000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
